// File: rtl/pmod_i2s2_pkg.sv
// Shared types and constants for the Pmod I2S2 interface.
package pmod_i2s2_pkg;
  localparam int unsigned SAMPLE_WIDTH = 24;
  localparam int unsigned SLOTS_PER_CH = 32;
  localparam int unsigned FRAME_CNT_W  = 9;
  localparam int unsigned SLOT_W       = 5;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  // True for slots 1..SAMPLE_WIDTH, which carry MSB..LSB.
  function automatic logic is_data_slot(input logic [SLOT_W-1:0] slot);
    return (slot >= SLOT_W'(1)) && (slot <= SLOT_W'(SAMPLE_WIDTH));
  endfunction

  // Serial bit of a word for a given slot; zero in the delay and pad slots.
  function automatic logic tx_bit(input sample_t w, input logic [SLOT_W-1:0] slot);
    logic [SLOT_W-1:0] idx;
    idx = SLOT_W'(SAMPLE_WIDTH) - slot;
    if (is_data_slot(slot)) return w[idx];
    return 1'b0;
  endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// Frame counter and derived MCLK/SCLK/LRCK plus per-slot strobes.
module i2s_clkgen
  import pmod_i2s2_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic [FRAME_CNT_W-1:0] cnt_o,
  output logic                   mclk_o,
  output logic                   sclk_o,
  output logic                   lrck_o,
  output logic                   capture_stb_c,
  output logic                   shift_stb_c,
  output logic                   frame_start_c
);
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   mclk_q, sclk_q, lrck_q;

  // Free-running wrap counter.
  always_comb begin
    cnt_d = FRAME_CNT_W'(cnt_q + 1'b1);
  end

  // Clock flops load from the next count so they stay aligned with cnt_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
      sclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= cnt_d[0];
      sclk_q <= cnt_d[2];
      lrck_q <= cnt_d[FRAME_CNT_W-1];
    end
  end

  // Capture just after SCLK rise; shift one cycle before SCLK fall.
  always_comb begin
    capture_stb_c = (cnt_q[2:0] == 3'b100);
    shift_stb_c   = (cnt_q[2:0] == 3'b111);
    frame_start_c = (cnt_q == '0);
  end

  assign cnt_o  = cnt_q;
  assign mclk_o = mclk_q;
  assign sclk_o = sclk_q;
  assign lrck_o = lrck_q;
endmodule

// File: rtl/pmod_i2s2_if.sv
// Pmod I2S2 top: clock generation, ADC deserialiser and DAC serialiser.
module pmod_i2s2_if
  import pmod_i2s2_pkg::*;
(
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    lin_sdout_in,
  output logic    lin_mclk_out,
  output logic    lin_sclk_out,
  output logic    lin_lrck_out,
  output logic    lout_mclk_out,
  output logic    lout_sclk_out,
  output logic    lout_lrck_out,
  output logic    lout_sdin_out,
  output sample_t left_out,
  output sample_t right_out,
  output logic    valid_out,
  input  sample_t left_in,
  input  sample_t right_in
);
  logic [FRAME_CNT_W-1:0] cnt, tx_cnt;
  logic                   mclk, sclk, lrck;
  logic                   capture_stb, shift_stb, frame_start;
  logic [SLOT_W-1:0]      rx_slot;
  logic                   rx_data, rx_last;

  sample_t left_sr_q, left_sr_d, right_sr_q, right_sr_d, shadow_q, shadow_d;
  stereo_t out_q, out_d, lat_q, lat_d;
  logic    pend_q, pend_d, valid_q, valid_d, sdin_q, sdin_d;

  i2s_clkgen u_clkgen (
    .clk_i         (clk_in),
    .rst_ni        (rst_in),
    .cnt_o         (cnt),
    .mclk_o        (mclk),
    .sclk_o        (sclk),
    .lrck_o        (lrck),
    .capture_stb_c (capture_stb),
    .shift_stb_c   (shift_stb),
    .frame_start_c (frame_start)
  );

  assign rx_slot = cnt[SLOT_W+2:3];
  assign rx_data = is_data_slot(rx_slot);
  assign rx_last = (rx_slot == SLOT_W'(SAMPLE_WIDTH));
  assign tx_cnt  = FRAME_CNT_W'(cnt + 1'b1);

  // ADC deserialiser: per-channel shift, left shadow, frame publish.
  always_comb begin
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    shadow_d   = shadow_q;
    pend_d     = 1'b0;
    out_d      = out_q;
    valid_d    = 1'b0;
    if (capture_stb && rx_data) begin
      if (!cnt[FRAME_CNT_W-1]) begin
        left_sr_d = sample_t'({left_sr_q[SAMPLE_WIDTH-2:0], lin_sdout_in});
        if (rx_last) shadow_d = left_sr_d;
      end else begin
        right_sr_d = sample_t'({right_sr_q[SAMPLE_WIDTH-2:0], lin_sdout_in});
        if (rx_last) pend_d = 1'b1;
      end
    end
    if (pend_q) begin
      out_d.left  = shadow_q;
      out_d.right = right_sr_q;
      valid_d     = 1'b1;
    end
  end

  // DAC serialiser: latch words at frame start, present the next slot's bit at SCLK fall.
  always_comb begin
    lat_d  = lat_q;
    sdin_d = sdin_q;
    if (frame_start) begin
      lat_d.left  = left_in;
      lat_d.right = right_in;
    end
    if (shift_stb) begin
      sdin_d = tx_bit(tx_cnt[FRAME_CNT_W-1] ? lat_q.right : lat_q.left, tx_cnt[SLOT_W+2:3]);
    end
  end

  // Datapath state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      left_sr_q  <= '0;
      right_sr_q <= '0;
      shadow_q   <= '0;
      pend_q     <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      lat_q      <= '0;
      sdin_q     <= 1'b0;
    end else begin
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      lat_q      <= lat_d;
      sdin_q     <= sdin_d;
    end
  end

  assign lin_mclk_out  = mclk;
  assign lin_sclk_out  = sclk;
  assign lin_lrck_out  = lrck;
  assign lout_mclk_out = mclk;
  assign lout_sclk_out = sclk;
  assign lout_lrck_out = lrck;
  assign lout_sdin_out = sdin_q;
  assign left_out      = out_q.left;
  assign right_out     = out_q.right;
  assign valid_out     = valid_q;
endmodule

// File: tb/tb_pmod_i2s2_if.sv
// Directed bench for pmod_i2s2_if: frame table, toggle, loopback, clocks, reset.
module tb_pmod_i2s2_if;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        lin_sdout_in = 1'b0;
  logic        lin_mclk_out, lin_sclk_out, lin_lrck_out;
  logic        lout_mclk_out, lout_sclk_out, lout_lrck_out, lout_sdin_out;
  logic [23:0] left_out, right_out;
  logic        valid_out;
  logic [23:0] left_in = '0, right_in = '0;

  pmod_i2s2_if dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .lin_sdout_in  (lin_sdout_in),
    .lin_mclk_out  (lin_mclk_out),
    .lin_sclk_out  (lin_sclk_out),
    .lin_lrck_out  (lin_lrck_out),
    .lout_mclk_out (lout_mclk_out),
    .lout_sclk_out (lout_sclk_out),
    .lout_lrck_out (lout_lrck_out),
    .lout_sdin_out (lout_sdin_out),
    .left_out      (left_out),
    .right_out     (right_out),
    .valid_out     (valid_out),
    .left_in       (left_in),
    .right_in      (right_in)
  );

  always #10 clk_in = ~clk_in;

  // Reference frame position: cnt as the specification defines it.
  logic [8:0] m_cnt;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) m_cnt <= '0;
    else         m_cnt <= m_cnt + 9'd1;
  end

  typedef struct {
    logic [23:0] adc_l, adc_r;
    logic        pad;
    logic [23:0] dac_l, dac_r;
    logic [23:0] exp_l, exp_r, exp_dl, exp_dr;
  } vec_t;
  vec_t tbl[4];

  int checks = 0, errors = 0;

  // Scoreboard / decoder state.
  logic [23:0] sb_l, sb_r, sb_sh, sb_exp_l, sb_exp_r;
  logic        sb_ready;
  logic [23:0] dsr_l, dsr_r, dec_l, dec_r;
  logic        prev_sclk;
  int          vcount, pad_err, tog_cnt;
  logic [23:0] pat_l, pat_r;
  logic        pat_pad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_clear();
    sb_l = '0; sb_r = '0; sb_sh = '0; sb_exp_l = '0; sb_exp_r = '0; sb_ready = 1'b0;
    dsr_l = '0; dsr_r = '0; prev_sclk = 1'b0;
  endtask

  // One clock cycle, entered at a falling edge: observe, drive, model the capture.
  task automatic step(input int mode);
    int          slot;
    logic        ch;
    logic [23:0] w;
    if (valid_out === 1'b1) begin
      vcount++;
      chk("sb_ready", 32'(sb_ready), 32'd1);
      chk("sb_left", 32'(left_out), 32'(sb_exp_l));
      chk("sb_right", 32'(right_out), 32'(sb_exp_r));
      sb_ready = 1'b0;
    end
    slot = int'(m_cnt[7:3]);
    ch   = m_cnt[8];
    if (lout_sclk_out === 1'b1 && prev_sclk === 1'b0) begin
      if (slot >= 1 && slot <= 24) begin
        if (!ch) dsr_l = {dsr_l[22:0], lout_sdin_out};
        else     dsr_r = {dsr_r[22:0], lout_sdin_out};
        if (slot == 24 && !ch) dec_l = dsr_l;
        if (slot == 24 && ch)  dec_r = dsr_r;
      end else if (lout_sdin_out !== 1'b0) begin
        pad_err++;
      end
    end
    prev_sclk = lout_sclk_out;
    case (mode)
      0: begin
        w = ch ? pat_r : pat_l;
        lin_sdout_in = (slot >= 1 && slot <= 24) ? w[24-slot] : pat_pad;
      end
      1: begin
        tog_cnt++;
        if (tog_cnt == 12) begin
          lin_sdout_in = ~lin_sdout_in;
          tog_cnt = 0;
        end
      end
      default: lin_sdout_in = lout_sdin_out;
    endcase
    if (m_cnt[2:0] == 3'd4 && slot >= 1 && slot <= 24) begin
      if (!ch) begin
        sb_l = {sb_l[22:0], lin_sdout_in};
        if (slot == 24) sb_sh = sb_l;
      end else begin
        sb_r = {sb_r[22:0], lin_sdout_in};
        if (slot == 24) begin
          sb_exp_l = sb_sh; sb_exp_r = sb_r; sb_ready = 1'b1;
        end
      end
    end
    @(negedge clk_in);
  endtask

  // One full frame starting at cnt==0.
  task automatic run_frame(input int mode, input logic [23:0] dl, input logic [23:0] dr,
                           input logic [23:0] edl, input logic [23:0] edr);
    left_in = dl; right_in = dr;
    vcount = 0; pad_err = 0; dec_l = 'x; dec_r = 'x;
    for (int i = 0; i < 512; i++) step(mode);
    chk("valid_pulses", 32'(vcount), 32'd1);
    chk("dac_pad_zero", 32'(pad_err), 32'd0);
    chk("dac_left", 32'(dec_l), 32'(edl));
    chk("dac_right", 32'(dec_r), 32'(edr));
  endtask

  initial begin
    int   r_m, r_s, r_l, diff, vc, first_s, first_l, early_v;
    logic pm, ps, pl;

    tbl[0] = '{24'hF0AA11, 24'h0F55EE, 1'b1, 24'h800001, 24'h7FFFFE,
               24'hF0AA11, 24'h0F55EE, 24'h800001, 24'h7FFFFE};
    tbl[1] = '{24'h000000, 24'hFFFFFF, 1'b1, 24'h000000, 24'hFFFFFF,
               24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    tbl[2] = '{24'h800000, 24'h000001, 1'b0, 24'h555555, 24'hAAAAAA,
               24'h800000, 24'h000001, 24'h555555, 24'hAAAAAA};
    tbl[3] = '{24'h7FFFFF, 24'h800000, 1'b1, 24'h123456, 24'hFEDCBA,
               24'h7FFFFF, 24'h800000, 24'h123456, 24'hFEDCBA};

    sb_clear();
    tog_cnt = 0;
    repeat (3) @(negedge clk_in);
    chk("rst_outputs", 32'({lin_mclk_out, lin_sclk_out, lin_lrck_out, lout_mclk_out,
                            lout_sclk_out, lout_lrck_out, lout_sdin_out, valid_out}), 32'd0);
    chk("rst_left", 32'(left_out), 32'd0);
    chk("rst_right", 32'(right_out), 32'd0);
    rst_in = 1'b1;

    // Table-driven ADC/DAC frames.
    for (int k = 0; k < 4; k++) begin
      pat_l = tbl[k].adc_l; pat_r = tbl[k].adc_r; pat_pad = tbl[k].pad;
      run_frame(0, tbl[k].dac_l, tbl[k].dac_r, tbl[k].exp_dl, tbl[k].exp_dr);
      chk("tbl_left", 32'(left_out), 32'(tbl[k].exp_l));
      chk("tbl_right", 32'(right_out), 32'(tbl[k].exp_r));
    end

    // Input toggling every 12 cycles, asynchronous to SCLK.
    run_frame(1, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE);
    run_frame(1, 24'h0C0FFE, 24'hABCDEF, 24'h0C0FFE, 24'hABCDEF);

    // Loopback DAC -> ADC.
    run_frame(2, 24'h3A5C7E, 24'hC1D2E3, 24'h3A5C7E, 24'hC1D2E3);
    chk("loop_left0", 32'(left_out), 32'h3A5C7E);
    chk("loop_right0", 32'(right_out), 32'hC1D2E3);
    run_frame(2, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE);
    chk("loop_left1", 32'(left_out), 32'h800001);
    chk("loop_right1", 32'(right_out), 32'h7FFFFE);

    // Clock ratios over 2048 cycles.
    r_m = 0; r_s = 0; r_l = 0; diff = 0; vc = 0;
    pm = lin_mclk_out; ps = lin_sclk_out; pl = lin_lrck_out;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk_in);
      if (lin_mclk_out && !pm) r_m++;
      if (lin_sclk_out && !ps) r_s++;
      if (lin_lrck_out && !pl) r_l++;
      if (valid_out) vc++;
      if ({lout_mclk_out, lout_sclk_out, lout_lrck_out} !==
          {lin_mclk_out, lin_sclk_out, lin_lrck_out}) diff++;
      pm = lin_mclk_out; ps = lin_sclk_out; pl = lin_lrck_out;
    end
    chk("mclk_periods", 32'(r_m), 32'd1024);
    chk("sclk_periods", 32'(r_s), 32'd256);
    chk("lrck_periods", 32'(r_l), 32'd4);
    chk("lout_eq_lin", 32'(diff), 32'd0);
    chk("valid_rate", 32'(vc), 32'd4);

    // Mid-frame reset: outputs clear at once and the partial frame is dropped.
    pat_l = 24'hA5A5A5; pat_r = 24'h5A5A5A; pat_pad = 1'b0;
    for (int i = 0; i < 300; i++) step(0);
    rst_in = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'({lin_mclk_out, lin_sclk_out, lin_lrck_out, lout_mclk_out,
                                lout_sclk_out, lout_lrck_out, lout_sdin_out, valid_out}), 32'd0);
    chk("mid_rst_left", 32'(left_out), 32'd0);
    chk("mid_rst_right", 32'(right_out), 32'd0);
    vc = 0;
    repeat (2) begin
      @(negedge clk_in);
      if (valid_out !== 1'b0) vc++;
    end
    chk("mid_rst_no_valid", 32'(vc), 32'd0);
    sb_clear();
    rst_in = 1'b1;
    first_s = -1; first_l = -1; early_v = 0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk_in);
      #1;
      if (first_s < 0 && lin_sclk_out) first_s = i;
      if (first_l < 0 && lin_lrck_out) first_l = i;
      if (i < 400 && valid_out) early_v++;
      if (i == 400) chk("partial_dropped", 32'(left_out), 32'd0);
    end
    chk("first_sclk_rise", 32'(first_s), 32'd4);
    chk("first_lrck_rise", 32'(first_l), 32'd256);
    chk("no_early_valid", 32'(early_v), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
